// File: rtl/trapezoid_filter_v2_pkg.sv
// Shared settings for the runtime-configurable trapezoidal shaper: widths, depth,
// state encoding and the config / saturation helpers.
package package_settings_V2;

    localparam int SIZE_IN_DATA = 14;
    localparam int DEPTH        = 32;
    localparam int SIZE_CNT     = $clog2(DEPTH + 1);
    localparam int SIZE_M       = 8;
    localparam int SIZE_ACC     = 40;
    localparam int SIZE_OUT     = 16;
    localparam int SHIFT        = 0;
    localparam int SIZE_D       = SIZE_IN_DATA + 2;
    localparam int SIZE_PTR     = $clog2(DEPTH);

    localparam logic [SIZE_CNT:0]               DEPTH_EXT = (SIZE_CNT + 1)'(DEPTH);
    localparam logic signed [SIZE_ACC-1:0]      OUT_MAX   = SIZE_ACC'(2 ** (SIZE_OUT - 1) - 1);
    localparam logic signed [SIZE_ACC-1:0]      OUT_MIN   = SIZE_ACC'(-(2 ** (SIZE_OUT - 1)));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic logic cfg_valid(input logic [SIZE_CNT-1:0] k, input logic [SIZE_CNT-1:0] l);
        logic [SIZE_CNT:0] sum;
        sum = {1'b0, k} + {1'b0, l};
        return (k != {SIZE_CNT{1'b0}}) && (k <= l) && (sum <= DEPTH_EXT);
    endfunction

    // Returns {clipped, value} for the signed output range.
    function automatic logic [SIZE_OUT:0] saturate(input logic signed [SIZE_ACC-1:0] t);
        if (t > OUT_MAX) begin
            return {1'b1, OUT_MAX[SIZE_OUT-1:0]};
        end else if (t < OUT_MIN) begin
            return {1'b1, OUT_MIN[SIZE_OUT-1:0]};
        end else begin
            return {1'b0, t[SIZE_OUT-1:0]};
        end
    endfunction

endpackage

// File: rtl/trapezoid_filter_v2_delay_line.sv
// Circular sample history with three combinational taps; taps older than the
// first sample since reconfiguration read as zero.
module trap_delay_line
    import package_settings_V2::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [SIZE_IN_DATA-1:0] wr_data,
    input  logic [SIZE_CNT-1:0]     k,
    input  logic [SIZE_CNT-1:0]     l,
    input  logic [SIZE_CNT-1:0]     fill_cnt,
    output logic [SIZE_IN_DATA-1:0] tap_k,
    output logic [SIZE_IN_DATA-1:0] tap_l,
    output logic [SIZE_IN_DATA-1:0] tap_kl
);

    logic [SIZE_IN_DATA-1:0] mem_r [DEPTH];
    logic [SIZE_PTR-1:0]     wp_r;
    logic [SIZE_CNT:0]       kl_s;
    logic [SIZE_PTR-1:0]     addr_k_s;
    logic [SIZE_PTR-1:0]     addr_l_s;
    logic [SIZE_PTR-1:0]     addr_kl_s;

    // Tap addresses and fill masking; same-entry read during write sees old data.
    always_comb begin
        kl_s      = {1'b0, k} + {1'b0, l};
        addr_k_s  = wp_r - k[SIZE_PTR-1:0];
        addr_l_s  = wp_r - l[SIZE_PTR-1:0];
        addr_kl_s = wp_r - kl_s[SIZE_PTR-1:0];
        if (k > fill_cnt) begin
            tap_k = {SIZE_IN_DATA{1'b0}};
        end else begin
            tap_k = mem_r[addr_k_s];
        end
        if (l > fill_cnt) begin
            tap_l = {SIZE_IN_DATA{1'b0}};
        end else begin
            tap_l = mem_r[addr_l_s];
        end
        if (kl_s > {1'b0, fill_cnt}) begin
            tap_kl = {SIZE_IN_DATA{1'b0}};
        end else begin
            tap_kl = mem_r[addr_kl_s];
        end
    end

    // Write pointer, wrapping naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_r <= {SIZE_PTR{1'b0}};
        end else if (wr_en) begin
            wp_r <= wp_r + SIZE_PTR'(1);
        end else begin
            wp_r <= wp_r;
        end
    end

    // Sample storage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wp_r] <= wr_data;
        end
    end

endmodule

// File: rtl/trapezoid_filter_v2.sv
// Trapezoidal pulse shaper with runtime k/l/M, five-stage pipeline and
// saturated, scaled output.
module trapezoid_filter_v2
    import package_settings_V2::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SIZE_IN_DATA-1:0]    in_data,
    input  logic                       in_valid,
    input  logic                       cfg_load,
    input  logic [SIZE_CNT-1:0]        cfg_k,
    input  logic [SIZE_CNT-1:0]        cfg_l,
    input  logic [SIZE_M-1:0]          cfg_m,
    output logic                       cfg_err,
    output logic signed [SIZE_OUT-1:0] out_data,
    output logic                       out_valid,
    output logic                       out_sat,
    output logic                       fill_done
);

    state_t                      state_r;
    logic [SIZE_CNT-1:0]         k_r;
    logic [SIZE_CNT-1:0]         l_r;
    logic [SIZE_M-1:0]           m_r;
    logic [SIZE_CNT-1:0]         kl_s;
    logic [SIZE_CNT-1:0]         fill_cnt_r;
    logic                        accept_s;
    logic                        sample_s;
    logic [SIZE_IN_DATA-1:0]     tap_k_s;
    logic [SIZE_IN_DATA-1:0]     tap_l_s;
    logic [SIZE_IN_DATA-1:0]     tap_kl_s;
    logic signed [SIZE_D-1:0]    d_s;
    logic signed [SIZE_D-1:0]    d_r;
    logic signed [SIZE_D-1:0]    d2_r;
    logic signed [SIZE_ACC-1:0]  d1_acc_s;
    logic signed [SIZE_ACC-1:0]  d2_acc_s;
    logic signed [SIZE_ACC-1:0]  m_acc_s;
    logic signed [SIZE_ACC-1:0]  p_r;
    logic signed [SIZE_ACC-1:0]  r_r;
    logic signed [SIZE_ACC-1:0]  s_r;
    logic                        v1_r;
    logic                        v2_r;
    logic                        v3_r;
    logic                        v4_r;

    trap_delay_line u_delay_line (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (sample_s),
        .wr_data  (in_data),
        .k        (k_r),
        .l        (l_r),
        .fill_cnt (fill_cnt_r),
        .tap_k    (tap_k_s),
        .tap_l    (tap_l_s),
        .tap_kl   (tap_kl_s)
    );

    // Acceptance decisions, first difference and accumulator-width operands.
    always_comb begin
        accept_s = cfg_load && cfg_valid(cfg_k, cfg_l);
        sample_s = in_valid && !accept_s && (state_r != IDLE);
        kl_s     = k_r + l_r;
        d_s      = $signed({{(SIZE_D - SIZE_IN_DATA){1'b0}}, in_data})
                 - $signed({{(SIZE_D - SIZE_IN_DATA){1'b0}}, tap_k_s})
                 - $signed({{(SIZE_D - SIZE_IN_DATA){1'b0}}, tap_l_s})
                 + $signed({{(SIZE_D - SIZE_IN_DATA){1'b0}}, tap_kl_s});
        d1_acc_s = {{(SIZE_ACC - SIZE_D){d_r[SIZE_D-1]}}, d_r};
        d2_acc_s = {{(SIZE_ACC - SIZE_D){d2_r[SIZE_D-1]}}, d2_r};
        m_acc_s  = $signed({{(SIZE_ACC - SIZE_M){1'b0}}, m_r});
    end

    // Configuration registers, state and fill tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            k_r        <= {SIZE_CNT{1'b0}};
            l_r        <= {SIZE_CNT{1'b0}};
            m_r        <= {SIZE_M{1'b0}};
            fill_cnt_r <= {SIZE_CNT{1'b0}};
            fill_done  <= 1'b0;
            cfg_err    <= 1'b0;
        end else if (accept_s) begin
            state_r    <= FILL;
            k_r        <= cfg_k;
            l_r        <= cfg_l;
            m_r        <= cfg_m;
            fill_cnt_r <= {SIZE_CNT{1'b0}};
            fill_done  <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            if (cfg_load) begin
                cfg_err <= 1'b1;
            end
            if (sample_s && (fill_cnt_r != kl_s)) begin
                fill_cnt_r <= fill_cnt_r + SIZE_CNT'(1);
                if ((fill_cnt_r + SIZE_CNT'(1)) == kl_s) begin
                    fill_done <= 1'b1;
                    state_r   <= RUN;
                end
            end
        end
    end

    // Arithmetic pipeline: d, p (d re-timed), r, s, then scale and clip.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_r      <= 1'b0;
            v2_r      <= 1'b0;
            v3_r      <= 1'b0;
            v4_r      <= 1'b0;
            d_r       <= {SIZE_D{1'b0}};
            d2_r      <= {SIZE_D{1'b0}};
            p_r       <= {SIZE_ACC{1'b0}};
            r_r       <= {SIZE_ACC{1'b0}};
            s_r       <= {SIZE_ACC{1'b0}};
            out_valid <= 1'b0;
            out_data  <= {SIZE_OUT{1'b0}};
            out_sat   <= 1'b0;
        end else if (accept_s) begin
            // New config flushes every in-flight sample and restarts integration.
            v1_r      <= 1'b0;
            v2_r      <= 1'b0;
            v3_r      <= 1'b0;
            v4_r      <= 1'b0;
            p_r       <= {SIZE_ACC{1'b0}};
            s_r       <= {SIZE_ACC{1'b0}};
            out_valid <= 1'b0;
        end else begin
            v1_r <= sample_s;
            if (sample_s) begin
                d_r <= d_s;
            end
            v2_r <= v1_r;
            if (v1_r) begin
                p_r  <= p_r + d1_acc_s;
                d2_r <= d_r;
            end
            v3_r <= v2_r;
            if (v2_r) begin
                r_r <= p_r + m_acc_s * d2_acc_s;
            end
            v4_r <= v3_r;
            if (v3_r) begin
                s_r <= s_r + r_r;
            end
            out_valid <= v4_r;
            if (v4_r) begin
                {out_sat, out_data} <= saturate(s_r >>> SHIFT);
            end
        end
    end

endmodule

// File: tb/tb_trapezoid_filter_v2.sv
// Randomised bench for trapezoid_filter_v2 against a sample-history reference model.
module tb_trapezoid_filter_v2;
    import package_settings_V2::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] in_data = 14'd0;
    logic        in_valid = 1'b0;
    logic        cfg_load = 1'b0;
    logic [5:0]  cfg_k = 6'd0;
    logic [5:0]  cfg_l = 6'd0;
    logic [7:0]  cfg_m = 8'd0;
    logic        cfg_err;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_sat;
    logic        fill_done;

    trapezoid_filter_v2 dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m(cfg_m),
        .cfg_err(cfg_err), .out_data(out_data), .out_valid(out_valid),
        .out_sat(out_sat), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit     m_cfg;
    int     mk, ml, mm;
    int     hist[$];
    longint mp, ms, m_smax;
    bit     e_valid, e_sat, e_err, e_fill;
    longint e_data;
    longint sched[int];
    longint mdl_pulses[$];
    bit     mdl_sats[$];
    int     dut_pulses = 0;
    int     dut_pulse_cyc[$];

    longint t1_exp[8] = '{100, 300, 500, 700, 800, 800, 800, 800};
    longint t2_exp[8] = '{200, 500, 700, 900, 900, 800, 800, 800};

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic longint wrap_acc(input longint x);
        logic [SIZE_ACC-1:0] t;
        t = x[SIZE_ACC-1:0];
        return longint'($signed(t));
    endfunction

    function automatic int tap(input int i);
        return (i < 0) ? 0 : hist[i];
    endfunction

    task automatic model_reset();
        m_cfg = 0; mk = 0; ml = 0; mm = 0;
        hist.delete(); mp = 0; ms = 0;
        e_valid = 0; e_sat = 0; e_err = 0; e_fill = 0; e_data = 0;
        sched.delete();
    endtask

    // Reference behaviour at one rising clock edge, from the current inputs.
    task automatic model_edge();
        bit ok;
        int n;
        longint d, r, t;
        cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        ok = (cfg_k >= 1) && (cfg_k <= cfg_l) && (int'(cfg_k) + int'(cfg_l) <= DEPTH);
        if (cfg_load) begin
            if (ok) begin
                m_cfg = 1; mk = cfg_k; ml = cfg_l; mm = cfg_m;
                hist.delete(); mp = 0; ms = 0;
                e_err = 0; e_fill = 0;
                for (int c = cyc; c <= cyc + 4; c++) if (sched.exists(c)) sched.delete(c);
            end else begin
                e_err = 1;
            end
        end
        if (in_valid && m_cfg && !(cfg_load && ok)) begin
            hist.push_back(int'(in_data));
            n = hist.size() - 1;
            d = tap(n) - tap(n - mk) - tap(n - ml) + tap(n - mk - ml);
            mp = wrap_acc(mp + d);
            r = wrap_acc(mp + mm * d);
            ms = wrap_acc(ms + r);
            if (ms > m_smax) m_smax = ms;
            sched[cyc + 4] = ms;
            e_fill = (hist.size() >= mk + ml);
        end
        if (sched.exists(cyc)) begin
            t = sched[cyc] >>> SHIFT;
            if (t > 32767) begin e_data = 32767; e_sat = 1; end
            else if (t < -32768) begin e_data = -32768; e_sat = 1; end
            else begin e_data = t; e_sat = 0; end
            e_valid = 1;
            mdl_pulses.push_back(e_data);
            mdl_sats.push_back(e_sat);
        end else begin
            e_valid = 0;
        end
    endtask

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        chk("out_valid", longint'(out_valid), longint'(e_valid));
        chk("out_data", longint'($signed(out_data)), e_data);
        chk("out_sat", longint'(out_sat), longint'(e_sat));
        chk("cfg_err", longint'(cfg_err), longint'(e_err));
        chk("fill_done", longint'(fill_done), longint'(e_fill));
        if (out_valid) begin
            dut_pulses++;
            dut_pulse_cyc.push_back(cyc);
        end
    end

    task automatic step(input bit v, input int data);
        cfg_load = 1'b0;
        in_valid = v;
        in_data = 14'(data);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic load(input int k, input int l, input int m, input bit v, input int data);
        cfg_load = 1'b1;
        cfg_k = 6'(k); cfg_l = 6'(l); cfg_m = 8'(m);
        in_valid = v;
        in_data = 14'(data);
        @(posedge clk);
        model_edge();
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic run_basic(input int m, input string tag, input bit is_t2);
        int first_cyc;
        mdl_pulses.delete();
        dut_pulse_cyc.delete();
        load(2, 4, m, 0, 0);
        first_cyc = cyc + 1;
        for (int i = 0; i < 8; i++) begin
            step(1, 100);
            if (i == 4) chk({tag, "_fill_done_5th"}, longint'(fill_done), 0);
            if (i == 5) chk({tag, "_fill_done_6th"}, longint'(fill_done), 1);
        end
        repeat (6) step(0, 0);
        chk({tag, "_model_count"}, mdl_pulses.size(), 8);
        chk({tag, "_dut_count"}, dut_pulse_cyc.size(), 8);
        if (mdl_pulses.size() == 8) begin
            for (int i = 0; i < 8; i++)
                chk({tag, "_pulse"}, mdl_pulses[i], is_t2 ? t2_exp[i] : t1_exp[i]);
        end
        if (dut_pulse_cyc.size() > 0) chk({tag, "_latency"}, dut_pulse_cyc[0] - first_cyc, 4);
        else chk({tag, "_latency_pulse_seen"}, 0, 1);
    endtask

    initial begin
        int base, k, l, rr;
        model_reset();
        m_smax = 0;
        repeat (3) step(0, 0);
        reset = 1'b0;
        step(0, 0);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_data", longint'($signed(out_data)), 0);

        // Basic shapes with M=0 and M=1.
        run_basic(0, "t1", 0);
        run_basic(1, "t2", 1);

        // Full-depth triangle saturating.
        mdl_pulses.delete(); mdl_sats.delete(); m_smax = 0;
        load(16, 16, 0, 0, 0);
        repeat (40) step(1, 16383);
        repeat (6) step(0, 0);
        chk("t3_peak", m_smax, 4194048);
        if (mdl_pulses.size() >= 3) begin
            chk("t3_p0", mdl_pulses[0], 16383);
            chk("t3_s0", longint'(mdl_sats[0]), 0);
            chk("t3_p1", mdl_pulses[1], 32767);
            chk("t3_s1", longint'(mdl_sats[1]), 1);
            chk("t3_p2", mdl_pulses[2], 32767);
        end else chk("t3_pulses", mdl_pulses.size(), 40);

        // Rejected configs leave the running one alone.
        load(5, 3, 0, 0, 0);
        chk("t4_err_k_gt_l", longint'(cfg_err), 1);
        repeat (4) step(1, 16383);
        load(20, 20, 0, 0, 0);
        chk("t4_err_sum", longint'(cfg_err), 1);
        repeat (4) step(1, 1000);
        load(2, 4, 0, 0, 0);
        chk("t4_err_clear", longint'(cfg_err), 0);
        repeat (6) step(0, 0);

        // Reload with concurrent sample while samples are in flight.
        repeat (3) step(1, 100);
        mdl_pulses.delete();
        base = dut_pulses;
        load(2, 4, 0, 1, 100);
        repeat (8) step(1, 100);
        repeat (6) step(0, 0);
        chk("t5_dut_count", dut_pulses - base, 8);
        chk("t5_model_count", mdl_pulses.size(), 8);
        if (mdl_pulses.size() == 8)
            for (int i = 0; i < 8; i++) chk("t5_pulse", mdl_pulses[i], t1_exp[i]);

        // Reset mid-stream, then samples without a config.
        repeat (5) step(1, 100);
        reset = 1'b1;
        model_reset();
        repeat (2) step(1, 100);
        reset = 1'b0;
        base = dut_pulses;
        repeat (5) step(1, 100);
        repeat (6) step(0, 0);
        chk("t6_no_pulses", dut_pulses - base, 0);
        chk("t6_out_data", longint'($signed(out_data)), 0);
        chk("t6_fill_done", longint'(fill_done), 0);

        // Randomised configurations and traffic.
        for (int ci = 0; ci < 12; ci++) begin
            if (ci == 0) begin k = 12; l = 20; end
            else if (ci == 1) begin k = 1; l = 1; end
            else if (ci == 2) begin k = 16; l = 16; end
            else begin k = $urandom_range(1, 16); l = $urandom_range(k, 32 - k); end
            load(k, l, (ci == 2) ? 255 : $urandom_range(0, 255), 0, 0);
            for (int j = 0; j < 250; j++) begin
                rr = $urandom_range(0, 99);
                if (rr < 2) load($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 255), 0, 0);
                else if (rr < 3) begin
                    k = $urandom_range(1, 16);
                    load(k, $urandom_range(k, 32 - k), $urandom_range(0, 255),
                         1'($urandom_range(0, 1)), $urandom_range(0, 16383));
                end
                else step(rr < 70, $urandom_range(0, 16383));
            end
        end
        repeat (6) step(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
